mem_access_unit: RTL and testbench

Load/store stage between the execute stage and data memory in the SCC core. Takes one memory operation from execute and drives a request/acknowledge handshake to data memory. Handles byte/halfword/word lane alignment and load sign/zero extension, then returns load data to the register-file write port. Raises a stall while an access is in flight, and faults misaligned, malformed or timed-out accesses.

---
 rtl/scc_mem_pkg.sv | 20 ++
 rtl/lsu_lane_align.sv | 52 +++++
 rtl/mem_access_unit.sv | 169 ++++++++++++++++
 tb/tb_mem_access_unit.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/scc_mem_pkg.sv
// Shared definitions for the SCC load/store stage:
// access size codes, byte-enable patterns and FSM state.
package scc_mem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  localparam logic [3:0] BE_B0   = 4'b0001;
  localparam logic [3:0] BE_LO   = 4'b0011;
  localparam logic [3:0] BE_HI   = 4'b1100;
  localparam logic [3:0] BE_WORD = 4'b1111;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

endpackage

// File: rtl/lsu_lane_align.sv
// Byte-lane steering: store replication, byte enables,
// load lane select with sign/zero extension, misalignment.
module lsu_lane_align
  import scc_mem_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  addr_lo,
  input  logic        is_signed,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata_rep,
  output logic [31:0] rdata_ext,
  output logic        misalign
);

  logic [31:0] shifted;
  logic [7:0]  rbyte;
  logic [15:0] rhalf;

  assign shifted = rdata >> {addr_lo, 3'b000};
  assign rbyte   = shifted[7:0];
  assign rhalf   = addr_lo[1] ? rdata[31:16] : rdata[15:0];

  always_comb begin
    be        = '0;
    wdata_rep = '0;
    rdata_ext = '0;
    misalign  = 1'b0;
    unique case (size)
      SZ_BYTE: begin
        be        = BE_B0 << addr_lo;
        wdata_rep = {4{wdata[7:0]}};
        rdata_ext = {{24{is_signed & rbyte[7]}}, rbyte};
      end
      SZ_HALF: begin
        misalign  = addr_lo[0];
        be        = addr_lo[1] ? BE_HI : BE_LO;
        wdata_rep = {2{wdata[15:0]}};
        rdata_ext = {{16{is_signed & rhalf[15]}}, rhalf};
      end
      SZ_WORD: begin
        misalign  = |addr_lo;
        be        = BE_WORD;
        wdata_rep = wdata;
        rdata_ext = rdata;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store stage: one access at a time over a req/ack
// handshake to data memory, with fault and timeout handling.
module mem_access_unit
  import scc_mem_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ex_valid,
  input  logic        ex_load,
  input  logic        ex_store,
  input  logic [1:0]  ex_size,
  input  logic        ex_signed,
  input  logic [31:0] ex_addr,
  input  logic [31:0] ex_wdata,
  input  logic [2:0]  ex_dest,
  output logic        stall,
  output logic        wb_valid,
  output logic [2:0]  wb_addr,
  output logic [31:0] wb_data,
  output logic        fault,
  output logic [31:0] fault_addr,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] data_addr,
  output logic [3:0]  data_be,
  output logic [31:0] data_out,
  input  logic        mem_ack,
  input  logic [31:0] data_in
);

  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t state, state_next;
  logic   busy;
  logic [15:0] cnt;

  logic        op_load;
  logic        op_signed;
  logic [1:0]  op_size;
  logic [31:0] op_addr;
  logic [2:0]  op_dest;

  logic [1:0]  al_size;
  logic [1:0]  al_lo;
  logic        al_signed;
  logic [3:0]  al_be;
  logic [31:0] al_wdata;
  logic [31:0] al_rdata;
  logic        al_misalign;

  logic bad;
  logic accept_ok;
  logic accept_bad;
  logic done;
  logic tmo;

  assign busy    = (state == BUSY);
  assign stall   = busy;
  assign mem_req = busy;

  // Aligner sees the incoming op in IDLE, the held op in BUSY
  assign al_size   = busy ? op_size      : ex_size;
  assign al_lo     = busy ? op_addr[1:0] : ex_addr[1:0];
  assign al_signed = busy ? op_signed    : ex_signed;

  lsu_lane_align u_align (
    .size      (al_size),
    .addr_lo   (al_lo),
    .is_signed (al_signed),
    .wdata     (ex_wdata),
    .rdata     (data_in),
    .be        (al_be),
    .wdata_rep (al_wdata),
    .rdata_ext (al_rdata),
    .misalign  (al_misalign)
  );

  assign bad = (ex_load == ex_store)
             || (ex_size == SZ_RSVD)
             || al_misalign;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    accept_ok  = 1'b0;
    accept_bad = 1'b0;
    done       = 1'b0;
    tmo        = 1'b0;
    unique case (state)
      IDLE: begin
        if (ex_valid) begin
          if (bad) begin
            accept_bad = 1'b1;
          end else begin
            accept_ok  = 1'b1;
            state_next = BUSY;
          end
        end
      end
      BUSY: begin
        if (mem_ack) begin
          done       = 1'b1;
          state_next = IDLE;
        end else if (cnt == TMO_LAST) begin
          tmo        = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt        <= '0;
      op_load    <= 1'b0;
      op_signed  <= 1'b0;
      op_size    <= '0;
      op_addr    <= '0;
      op_dest    <= '0;
      mem_we     <= 1'b0;
      data_addr  <= '0;
      data_be    <= '0;
      data_out   <= '0;
      wb_valid   <= 1'b0;
      wb_addr    <= '0;
      wb_data    <= '0;
      fault      <= 1'b0;
      fault_addr <= '0;
    end else begin
      wb_valid <= 1'b0;
      fault    <= 1'b0;
      if (accept_bad) begin
        fault      <= 1'b1;
        fault_addr <= ex_addr;
      end
      if (accept_ok) begin
        cnt       <= '0;
        op_load   <= ex_load;
        op_signed <= ex_signed;
        op_size   <= ex_size;
        op_addr   <= ex_addr;
        op_dest   <= ex_dest;
        mem_we    <= ex_store;
        data_addr <= {ex_addr[31:2], 2'b00};
        data_be   <= al_be;
        data_out  <= al_wdata;
      end else if (busy) begin
        cnt <= cnt + 16'd1;
      end
      if (done && op_load) begin
        wb_valid <= 1'b1;
        wb_addr  <= op_dest;
        wb_data  <= al_rdata;
      end
      if (tmo) begin
        fault      <= 1'b1;
        fault_addr <= op_addr;
      end
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: directed ops push
// expected requests, write-backs and faults; a monitor checks.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        ex_valid = 1'b0;
  logic        ex_load = 1'b0;
  logic        ex_store = 1'b0;
  logic [1:0]  ex_size = '0;
  logic        ex_signed = 1'b0;
  logic [31:0] ex_addr = '0;
  logic [31:0] ex_wdata = '0;
  logic [2:0]  ex_dest = '0;
  logic        stall;
  logic        wb_valid;
  logic [2:0]  wb_addr;
  logic [31:0] wb_data;
  logic        fault;
  logic [31:0] fault_addr;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] data_addr;
  logic [3:0]  data_be;
  logic [31:0] data_out;
  logic        mem_ack = 1'b0;
  logic [31:0] data_in = '0;

  mem_access_unit #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .reset(reset),
    .ex_valid(ex_valid), .ex_load(ex_load),
    .ex_store(ex_store), .ex_size(ex_size),
    .ex_signed(ex_signed), .ex_addr(ex_addr),
    .ex_wdata(ex_wdata), .ex_dest(ex_dest),
    .stall(stall), .wb_valid(wb_valid),
    .wb_addr(wb_addr), .wb_data(wb_data),
    .fault(fault), .fault_addr(fault_addr),
    .mem_req(mem_req), .mem_we(mem_we),
    .data_addr(data_addr), .data_be(data_be),
    .data_out(data_out), .mem_ack(mem_ack),
    .data_in(data_in)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  dest;
    logic [31:0] data;
    int          cyc;
  } wb_exp_t;

  typedef struct {
    logic [31:0] addr;
    int          cyc;
  } flt_exp_t;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] dout;
    logic        we;
  } req_exp_t;

  wb_exp_t  wbq[$];
  flt_exp_t fq[$];
  req_exp_t rq[$];

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  logic prev_req = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin : monitor
    wb_exp_t  we_e;
    flt_exp_t fe;
    req_exp_t re;
    if (wb_valid || fault)
      chk("wb_fault_excl", {31'd0, wb_valid & fault}, 0);
    if (wb_valid) begin
      if (wbq.size() == 0) chk("wb_unexpected", 1, 0);
      else begin
        we_e = wbq.pop_front();
        chk("wb_addr", {29'd0, wb_addr}, {29'd0, we_e.dest});
        chk("wb_data", wb_data, we_e.data);
        chk("wb_cycle", cyc, we_e.cyc);
      end
    end
    if (fault) begin
      if (fq.size() == 0) chk("fault_unexpected", 1, 0);
      else begin
        fe = fq.pop_front();
        chk("fault_addr", fault_addr, fe.addr);
        chk("fault_cycle", cyc, fe.cyc);
      end
    end
    if (mem_req && !prev_req) begin
      if (rq.size() == 0) chk("req_unexpected", 1, 0);
      else begin
        re = rq.pop_front();
        chk("data_addr", data_addr, re.addr);
        chk("data_be", {28'd0, data_be}, {28'd0, re.be});
        chk("data_out", data_out, re.dout);
        chk("mem_we", {31'd0, mem_we}, {31'd0, re.we});
      end
    end
    prev_req = mem_req;
  end

  task automatic issue(input logic ld, input logic st,
                       input logic [1:0] sz, input logic sg,
                       input logic [31:0] a, input logic [31:0] wd,
                       input logic [2:0] d, output int acc);
    @(negedge clk);
    ex_valid = 1'b1; ex_load = ld; ex_store = st;
    ex_size = sz; ex_signed = sg; ex_addr = a;
    ex_wdata = wd; ex_dest = d;
    @(posedge clk);
    #1;
    ex_valid = 1'b0; ex_load = 1'b0; ex_store = 1'b0;
    acc = cyc;
  endtask

  task automatic ack(input int w, input logic [31:0] rd);
    @(negedge clk);
    chk("stall_busy", {31'd0, stall}, 1);
    repeat (w) @(negedge clk);
    mem_ack = 1'b1;
    data_in = rd;
    @(posedge clk);
    #1;
    mem_ack = 1'b0;
  endtask

  task automatic do_load(input logic [1:0] sz, input logic sg,
                         input logic [31:0] a, input logic [2:0] d,
                         input logic [31:0] rd, input int w,
                         input logic [3:0] be, input logic [31:0] exp);
    int acc;
    rq.push_back('{{a[31:2], 2'b00}, be, 32'd0, 1'b0});
    issue(1'b1, 1'b0, sz, sg, a, 32'd0, d, acc);
    wbq.push_back('{d, exp, acc + 1 + w});
    ack(w, rd);
  endtask

  task automatic do_store(input logic [1:0] sz, input logic [31:0] a,
                          input logic [31:0] wd, input logic [3:0] be,
                          input logic [31:0] dout);
    int acc;
    rq.push_back('{{a[31:2], 2'b00}, be, dout, 1'b1});
    issue(1'b0, 1'b1, sz, 1'b0, a, wd, 3'd0, acc);
    ack(1, 32'hFFFF_FFFF);
  endtask

  task automatic do_fault(input logic ld, input logic st,
                          input logic [1:0] sz, input logic [31:0] a);
    int acc;
    issue(ld, st, sz, 1'b0, a, 32'h1234_5678, 3'd6, acc);
    fq.push_back('{a, acc});
    @(negedge clk);
    chk("fault_no_stall", {30'd0, stall, mem_req}, 0);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int acc;
    #2;
    chk("rst_ctrl", {27'd0, stall, mem_req, mem_we, wb_valid, fault}, 0);
    chk("rst_data_addr", data_addr, 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;

    do_load(2'b10, 1'b0, 32'h100, 3'd5, 32'hDEAD_BEEF, 0, 4'hF, 32'hDEAD_BEEF);
    do_load(2'b00, 1'b1, 32'h103, 3'd1, 32'h8012_3456, 0, 4'h8, 32'hFFFF_FF80);
    do_load(2'b00, 1'b0, 32'h103, 3'd2, 32'h8012_3456, 2, 4'h8, 32'h0000_0080);
    do_load(2'b01, 1'b1, 32'h102, 3'd3, 32'h8001_1234, 1, 4'hC, 32'hFFFF_8001);
    do_load(2'b00, 1'b1, 32'h101, 3'd4, 32'h0000_7F00, 0, 4'h2, 32'h0000_007F);
    do_load(2'b01, 1'b0, 32'h100, 3'd0, 32'h0000_F00D, 0, 4'h3, 32'h0000_F00D);

    do_store(2'b01, 32'h202, 32'h0000_ABCD, 4'hC, 32'hABCD_ABCD);
    do_store(2'b00, 32'h201, 32'h0000_00A5, 4'h2, 32'hA5A5_A5A5);
    do_store(2'b10, 32'h204, 32'h1122_3344, 4'hF, 32'h1122_3344);

    do_fault(1'b1, 1'b0, 2'b10, 32'h105);
    do_fault(1'b1, 1'b0, 2'b01, 32'h107);
    do_fault(1'b1, 1'b0, 2'b11, 32'h40);
    do_fault(1'b1, 1'b1, 2'b10, 32'h44);
    do_fault(1'b0, 1'b0, 2'b00, 32'h48);

    // ack with nothing in flight
    @(negedge clk);
    mem_ack = 1'b1;
    @(posedge clk);
    #1 mem_ack = 1'b0;

    // timeout with ack withheld, then a stale ack
    rq.push_back('{32'h300, 4'hF, 32'd0, 1'b0});
    issue(1'b1, 1'b0, 2'b10, 1'b0, 32'h300, 32'd0, 3'd2, acc);
    fq.push_back('{32'h300, acc + 4});
    repeat (6) @(negedge clk);
    chk("tmo_req_drop", {30'd0, stall, mem_req}, 0);
    mem_ack = 1'b1;
    data_in = 32'h5555_5555;
    @(posedge clk);
    #1 mem_ack = 1'b0;
    repeat (2) @(negedge clk);

    // reset during BUSY
    rq.push_back('{32'h500, 4'hF, 32'd0, 1'b0});
    issue(1'b1, 1'b0, 2'b10, 1'b0, 32'h500, 32'd0, 3'd3, acc);
    @(negedge clk);
    chk("pre_rst_req", {31'd0, mem_req}, 1);
    #2 reset = 1'b0;
    #1;
    chk("rst_busy_ctrl", {27'd0, stall, mem_req, mem_we, wb_valid, fault}, 0);
    chk("rst_busy_addr", data_addr, 0);
    chk("rst_busy_be", {28'd0, data_be}, 0);
    chk("rst_busy_fault_addr", fault_addr, 0);
    @(negedge clk);
    reset = 1'b1;

    do_load(2'b10, 1'b0, 32'h400, 3'd7, 32'h1234_5678, 0, 4'hF, 32'h1234_5678);

    repeat (4) @(negedge clk);
    chk("wbq_empty", wbq.size(), 0);
    chk("fq_empty", fq.size(), 0);
    chk("rq_empty", rq.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
